// File: rtl/rsz_obs_pkg.sv
// Shared types and constants for the fanout observer: FSM encoding,
// signature polynomial/seed and the unload frame width helper.
package rsz_obs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    UNLOAD  = 2'd2
  } obs_state_t;

  localparam logic [15:0] SIG_POLY = 16'hB400;
  localparam logic [15:0] SIG_SEED = 16'hFFFF;

  // Unload frame is {sticky_err, mismatch_cnt, sig}, shifted MSB first.
  function automatic int frame_w(input int cnt_w, input int sig_w);
    return 1 + cnt_w + sig_w;
  endfunction

endpackage

// File: rtl/fanout_observer_if.sv
// Bus bundle between the fanout observer and whatever drives/reads it.
// The observer is the slave side; a test harness or wrapper is the master.
interface fanout_observer_if #(
  parameter int NUM_LOADS = 4,
  parameter int CNT_W     = 8,
  parameter int SIG_W     = 16
);
  import rsz_obs_pkg::*;

  // Stimulus side
  logic                 en;
  logic [NUM_LOADS-1:0] load_in;
  logic                 clear;
  logic                 unload_req;

  // Result side. so/so_valid is a pure strobe with no back-pressure: when
  // so_valid is high the receiver must take so on that clock edge; busy
  // stays high for the whole unload and done pulses one cycle afterwards.
  logic                 so;
  logic                 so_valid;
  logic                 busy;
  logic                 done;
  logic                 sticky_err;
  logic [CNT_W-1:0]     mismatch_cnt;
  logic [SIG_W-1:0]     sig;
  obs_state_t           state;

  modport master (
    output en, load_in, clear, unload_req,
    input  so, so_valid, busy, done, sticky_err, mismatch_cnt, sig, state
  );

  modport slave (
    input  en, load_in, clear, unload_req,
    output so, so_valid, busy, done, sticky_err, mismatch_cnt, sig, state
  );

endinterface

// File: rtl/fanout_observer_unload.sv
// Parallel-load shift register that streams a result frame MSB first,
// with a bit counter, a done pulse after the last bit and an abort input.
module fanout_observer_unload #(
  parameter int FRAME_W = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [FRAME_W-1:0] i_frame,
  output logic               o_so,
  output logic               o_so_valid,
  output logic               o_done,
  output logic               o_last
);

  localparam int CW = $clog2(FRAME_W);

  logic [FRAME_W-1:0] r_shift;
  logic [CW-1:0]      r_cnt;
  logic               r_so;
  logic               r_valid;
  logic               r_done;

  // The MSB goes straight to r_so on load; r_cnt counts bits still to show.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_so    <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_abort) begin
        r_cnt   <= '0;
        r_so    <= 1'b0;
        r_valid <= 1'b0;
      end else if (i_start) begin
        r_shift <= i_frame << 1;
        r_so    <= i_frame[FRAME_W-1];
        r_valid <= 1'b1;
        r_cnt   <= CW'(FRAME_W - 1);
      end else if (r_valid) begin
        if (r_cnt == '0) begin
          r_so    <= 1'b0;
          r_valid <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_so    <= r_shift[FRAME_W-1];
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign o_so       = r_so;
  assign o_so_valid = r_valid;
  assign o_done     = r_done;
  assign o_last     = r_valid && (r_cnt == '0);

endmodule

// File: rtl/fanout_observer.sv
// Load-end sink for a buffered net: checks that all load copies agree,
// counts disagreements, folds samples into an LFSR signature and unloads serially.
module fanout_observer
  import rsz_obs_pkg::*;
#(
  parameter int NUM_LOADS = 4,
  parameter int CNT_W     = 8,
  parameter int SIG_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  fanout_observer_if.slave bus
);

  localparam int FRAME_W = frame_w(CNT_W, SIG_W);
  localparam logic [SIG_W-1:0] POLY = SIG_W'(SIG_POLY);

  obs_state_t           r_state;
  obs_state_t           w_state_nxt;
  logic                 r_prev_mon;
  logic [NUM_LOADS-1:0] r_samp;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_err;
  logic [SIG_W-1:0]     r_sig;

  logic                 w_qual;
  logic                 w_mism;
  logic                 w_fb;
  logic [SIG_W-1:0]     w_sig_nxt;
  logic                 w_start;
  logic                 w_last;
  logic [FRAME_W-1:0]   w_frame;
  logic                 w_so;
  logic                 w_so_valid;
  logic                 w_done;

  // Clear outranks everything, including an unload request in the same cycle.
  assign w_start = !bus.clear && bus.unload_req && (r_state != UNLOAD);

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.unload_req)  w_state_nxt = UNLOAD;
          else if (bus.en)     w_state_nxt = MONITOR;
        end
        MONITOR: begin
          if (bus.unload_req)  w_state_nxt = UNLOAD;
          else if (!bus.en)    w_state_nxt = IDLE;
        end
        UNLOAD: begin
          if (w_last)          w_state_nxt = IDLE;
        end
        default:               w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_prev_mon <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev_mon <= (r_state == MONITOR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_samp <= '0;
    else        r_samp <= bus.load_in;
  end

  // Two MONITOR cycles in a row guarantee r_samp was captured while enabled.
  assign w_qual    = (r_state == MONITOR) && r_prev_mon;
  assign w_mism    = (r_samp != '0) && (r_samp != '1);
  assign w_fb      = ^(r_sig & POLY);
  assign w_sig_nxt = {r_sig[SIG_W-2:0], w_fb} ^ SIG_W'(r_samp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
      r_sig <= '1;
    end else if (bus.clear) begin
      r_cnt <= '0;
      r_err <= 1'b0;
      r_sig <= '1;
    end else if (w_qual) begin
      r_sig <= w_sig_nxt;
      if (w_mism) begin
        r_err <= 1'b1;
        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_frame = {r_err, r_cnt, r_sig};

  fanout_observer_unload #(
    .FRAME_W (FRAME_W)
  ) u_unload (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_start),
    .i_abort    (bus.clear),
    .i_frame    (w_frame),
    .o_so       (w_so),
    .o_so_valid (w_so_valid),
    .o_done     (w_done),
    .o_last     (w_last)
  );

  assign bus.so           = w_so;
  assign bus.so_valid     = w_so_valid;
  assign bus.busy         = w_so_valid;
  assign bus.done         = w_done;
  assign bus.sticky_err   = r_err;
  assign bus.mismatch_cnt = r_cnt;
  assign bus.sig          = r_sig;
  assign bus.state        = r_state;

endmodule
